// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - round-robin share of one FP add pipe with in-order tagged responses
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester handshake (ready is the one-hot grant)
//   req_a_i, req_b_i, req_rm_i,
//   req_warpid_i                   packed per-requester fields, requester i at [i*W +: W]
//   pipe_valid_o / pipe_ready_i    issue slot handshake to the add pipe
//   pipe_a_o, pipe_b_o, pipe_rm_o  issued operands and rounding mode
//   pipe_out_valid_i / _ready_o    add pipe result handshake
//   pipe_result_i, pipe_fflags_i   add pipe result and flags
//   rsp_valid_o / rsp_ready_i      tagged response handshake
//   rsp_id_o, rsp_warpid_o         originating requester and warp (tag FIFO head)
//   rsp_result_o, rsp_fflags_o     result and flags passed through from the pipe
//   inflight_o                     tags currently held (issued, not yet responded)
//   err_o                          sticky: pipe produced a result with no tag outstanding
module fadd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int EXPWIDTH     = 5,
  parameter int PRECISION    = 3,
  parameter int DEPTH_WARP   = 4,
  parameter int MAX_INFLIGHT = 4,
  localparam int DW  = EXPWIDTH + PRECISION + 1,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int PW  = $clog2(MAX_INFLIGHT),
  localparam int CW  = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DW-1:0]         req_a_i,
  input  logic [NUM_REQ*DW-1:0]         req_b_i,
  input  logic [NUM_REQ*3-1:0]          req_rm_i,
  input  logic [NUM_REQ*DEPTH_WARP-1:0] req_warpid_i,
  output logic                          pipe_valid_o,
  input  logic                          pipe_ready_i,
  output logic [DW-1:0]                 pipe_a_o,
  output logic [DW-1:0]                 pipe_b_o,
  output logic [2:0]                    pipe_rm_o,
  input  logic                          pipe_out_valid_i,
  output logic                          pipe_out_ready_o,
  input  logic [DW-1:0]                 pipe_result_i,
  input  logic [4:0]                    pipe_fflags_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [IDW-1:0]                rsp_id_o,
  output logic [DEPTH_WARP-1:0]         rsp_warpid_o,
  output logic [DW-1:0]                 rsp_result_o,
  output logic [4:0]                    rsp_fflags_o,
  output logic [CW-1:0]                 inflight_o,
  output logic                          err_o
);
  localparam int TW = IDW + DEPTH_WARP;

  logic           slot_free;
  logic           can_grant;
  logic           grant_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] rr;

  logic [TW-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_nonempty;
  logic           push;
  logic           pop;

  // The tag count covers the op sitting in the issue slot too, so a full FIFO
  // blocks grants even when the slot could drain this cycle.
  assign slot_free = !pipe_valid_o || pipe_ready_i;
  assign can_grant = slot_free && (count < CW'(MAX_INFLIGHT));

  // Round-robin scan starting at rr; NUM_REQ is a power of two so the index
  // addition wraps on its own.
  always_comb begin
    grant_any   = 1'b0;
    gnt_idx     = '0;
    scan_idx    = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr + IDW'(k);
      if (!grant_any && req_valid_i[scan_idx]) begin
        grant_any = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (!can_grant) grant_any = 1'b0;
    if (grant_any) req_ready_o[gnt_idx] = 1'b1;
  end

  // Issue slot: loads on grant, clears only when it has drained with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_o <= 1'b0;
      pipe_a_o     <= '0;
      pipe_b_o     <= '0;
      pipe_rm_o    <= '0;
      rr           <= '0;
    end else if (grant_any) begin
      pipe_valid_o <= 1'b1;
      pipe_a_o     <= req_a_i[int'(gnt_idx)*DW +: DW];
      pipe_b_o     <= req_b_i[int'(gnt_idx)*DW +: DW];
      pipe_rm_o    <= req_rm_i[int'(gnt_idx)*3 +: 3];
      rr           <= gnt_idx + IDW'(1);
    end else if (slot_free) begin
      pipe_valid_o <= 1'b0;
    end
  end

  // Response path is a pure pass-through; the tag FIFO head names the originator.
  assign fifo_nonempty    = (count != '0);
  assign rsp_valid_o      = pipe_out_valid_i && fifo_nonempty;
  // An orphan result (no tag outstanding) is drained regardless of rsp_ready_i.
  assign pipe_out_ready_o = rsp_ready_i || (pipe_out_valid_i && !fifo_nonempty);
  assign rsp_result_o     = pipe_result_i;
  assign rsp_fflags_o     = pipe_fflags_i;
  assign {rsp_id_o, rsp_warpid_o} = tag_mem[rd_ptr];

  assign push       = grant_any;
  assign pop        = rsp_valid_o && rsp_ready_i;
  assign inflight_o = count;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {gnt_idx, req_warpid_i[int'(gnt_idx)*DEPTH_WARP +: DEPTH_WARP]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pipe_out_valid_i && !fifo_nonempty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - scoreboard bench for fadd_arbiter with a 2-cycle add pipe model
module tb_fadd_arbiter;
  localparam int N  = 4;
  localparam int DW = 9;
  localparam int WW = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*DW-1:0] req_a_i;
  logic [N*DW-1:0] req_b_i;
  logic [N*3-1:0]  req_rm_i;
  logic [N*WW-1:0] req_warpid_i;
  logic            pipe_valid_o;
  logic            pipe_ready_i;
  logic [DW-1:0]   pipe_a_o;
  logic [DW-1:0]   pipe_b_o;
  logic [2:0]      pipe_rm_o;
  logic            pipe_out_valid_i;
  logic            pipe_out_ready_o;
  logic [DW-1:0]   pipe_result_i;
  logic [4:0]      pipe_fflags_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [1:0]      rsp_id_o;
  logic [WW-1:0]   rsp_warpid_o;
  logic [DW-1:0]   rsp_result_o;
  logic [4:0]      rsp_fflags_o;
  logic [CW-1:0]   inflight_o;
  logic            err_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fadd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i), .req_warpid_i(req_warpid_i),
    .pipe_valid_o(pipe_valid_o), .pipe_ready_i(pipe_ready_i),
    .pipe_a_o(pipe_a_o), .pipe_b_o(pipe_b_o), .pipe_rm_o(pipe_rm_o),
    .pipe_out_valid_i(pipe_out_valid_i), .pipe_out_ready_o(pipe_out_ready_o),
    .pipe_result_i(pipe_result_i), .pipe_fflags_i(pipe_fflags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_warpid_o(rsp_warpid_o),
    .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  typedef struct { int id; logic [WW-1:0] warp; logic [DW-1:0] res; logic [4:0] fl; } rsp_t;
  typedef struct { logic [DW-1:0] res; logic [4:0] fl; int age; } pipe_t;

  rsp_t  exp_q[$];
  rsp_t  got_q[$];
  int    gnt_q[$];
  pipe_t pq[$];

  // Add pipe model: result = a+b, flags = low bits of a^b, output two cycles after accept.
  logic          mv;
  logic          orphan;
  logic [DW-1:0] mres;
  logic [4:0]    mfl;
  assign pipe_out_valid_i = mv | orphan;
  assign pipe_result_i    = mres;
  assign pipe_fflags_i    = mfl;

  always @(posedge clk or negedge rst_n) begin
    pipe_t e;
    if (!rst_n) begin
      pq.delete();
      mv   <= 1'b0;
      mres <= '0;
      mfl  <= '0;
    end else begin
      if (mv && pipe_out_ready_o && pq.size() > 0) void'(pq.pop_front());
      foreach (pq[i]) pq[i].age++;
      if (pipe_valid_o && pipe_ready_i) begin
        e.res = pipe_a_o + pipe_b_o;
        e.fl  = 5'(pipe_a_o ^ pipe_b_o);
        e.age = 0;
        pq.push_back(e);
      end
      if (pq.size() > 0 && pq[0].age >= 1) begin
        mv   <= 1'b1;
        mres <= pq[0].res;
        mfl  <= pq[0].fl;
      end else begin
        mv <= 1'b0;
      end
    end
  end

  // Scoreboard collection: expectations from accepted requests, observations from responses.
  always @(negedge clk or negedge rst_n) begin
    rsp_t r;
    if (!rst_n) begin
      exp_q.delete();
      got_q.delete();
      gnt_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          r.id   = i;
          r.warp = req_warpid_i[i*WW +: WW];
          r.res  = req_a_i[i*DW +: DW] + req_b_i[i*DW +: DW];
          r.fl   = 5'(req_a_i[i*DW +: DW] ^ req_b_i[i*DW +: DW]);
          exp_q.push_back(r);
          gnt_q.push_back(i);
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        r.id   = int'(rsp_id_o);
        r.warp = rsp_warpid_o;
        r.res  = rsp_result_o;
        r.fl   = rsp_fflags_o;
        got_q.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    req_valid_i = '0;
    repeat (3) step();
    n_chk++;
    if ({pipe_valid_o, rsp_valid_o, err_o, inflight_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_during: got pv=%0b rv=%0b err=%0b infl=%0d rdy=%b expected all 0",
               pipe_valid_o, rsp_valid_o, err_o, inflight_o, req_ready_o);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if ({pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o, rsp_valid_o, err_o, inflight_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_after: got pv=%0b a=%0h b=%0h rm=%0d rv=%0b err=%0b infl=%0d expected all 0",
               pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o, rsp_valid_o, err_o, inflight_o);
    end
  endtask

  task automatic test_round_robin();
    rsp_t g, e;
    int k;
    gnt_q.delete();
    req_valid_i = '1;
    repeat (6) step();
    req_valid_i = '0;
    n_chk++;
    if (gnt_q.size() != 6) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d expected 6", gnt_q.size());
    end
    for (int i = 0; i < gnt_q.size(); i++) begin
      n_chk++;
      if (gnt_q[i] != i % N) begin
        n_fail++;
        $display("FAIL rr_grant_order[%0d]: got %0d expected %0d", i, gnt_q[i], i % N);
      end
    end
    for (int t = 0; t < 40 && got_q.size() < 6; t++) step();
    n_chk++;
    if (got_q.size() != 6) begin
      n_fail++;
      $display("FAIL rr_rsp_count: got %0d expected 6", got_q.size());
    end
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g.id !== k % N || g.id !== e.id || g.warp !== e.warp || g.warp !== 4'hA + 4'(k % N)
          || g.res !== e.res || g.fl !== e.fl) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got id=%0d warp=%0h res=%0h fl=%0h expected id=%0d warp=%0h res=%0h fl=%0h",
                 k, g.id, g.warp, g.res, g.fl, k % N, e.warp, e.res, e.fl);
      end
      k++;
    end
  endtask

  task automatic test_single();
    rsp_t g, e;
    req_a_i[2*DW +: DW] = 9'h03C;
    req_b_i[2*DW +: DW] = 9'h03C;
    req_valid_i = 4'b0100;
    #1;
    n_chk++;
    if (req_ready_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got %b expected 0100", req_ready_o);
    end
    step();
    req_valid_i = '0;
    n_chk++;
    if ({pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o} !== {1'b1, 9'h03C, 9'h03C, 3'd2}) begin
      n_fail++;
      $display("FAIL single_issue: got pv=%0b a=%0h b=%0h rm=%0d expected pv=1 a=3c b=3c rm=2",
               pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o);
    end
    step();
    n_chk++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_rsp: got rsp_valid=%0b expected 0", rsp_valid_o);
    end
    step();
    n_chk++;
    if ({rsp_valid_o, rsp_id_o, rsp_warpid_o, rsp_result_o, rsp_fflags_o} !== {1'b1, 2'd2, 4'hC, 9'h078, 5'h00}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%0b id=%0d warp=%0h res=%0h fl=%0h expected v=1 id=2 warp=c res=78 fl=0",
               rsp_valid_o, rsp_id_o, rsp_warpid_o, rsp_result_o, rsp_fflags_o);
    end
    step();
    n_chk++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_sb_count: got %0d/%0d expected 1/1", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g.id !== e.id || g.warp !== e.warp || g.res !== e.res || g.fl !== e.fl) begin
        n_fail++;
        $display("FAIL single_sb: got id=%0d res=%0h expected id=%0d res=%0h", g.id, g.res, e.id, e.res);
      end
    end
  endtask

  task automatic test_credit();
    rsp_t g, e;
    gnt_q.delete();
    rsp_ready_i = 1'b0;
    req_valid_i = '1;
    repeat (8) step();
    n_chk++;
    if (gnt_q.size() != 4 || req_ready_o !== '0 || inflight_o !== 3'd4) begin
      n_fail++;
      $display("FAIL credit_full: got grants=%0d rdy=%b infl=%0d expected grants=4 rdy=0000 infl=4",
               gnt_q.size(), req_ready_o, inflight_o);
    end
    rsp_ready_i = 1'b1;
    #1;
    n_chk++;
    if (req_ready_o !== '0 || rsp_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_rsp_ready_indep: got rdy=%b rv=%0b expected rdy=0000 rv=1", req_ready_o, rsp_valid_o);
    end
    step();
    rsp_ready_i = 1'b0;
    repeat (4) step();
    n_chk++;
    if (gnt_q.size() != 5 || got_q.size() != 1 || inflight_o !== 3'd4) begin
      n_fail++;
      $display("FAIL credit_one_more: got grants=%0d rsps=%0d infl=%0d expected 5/1/4",
               gnt_q.size(), got_q.size(), inflight_o);
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    for (int t = 0; t < 40 && got_q.size() < 5; t++) step();
    n_chk++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      n_fail++;
      $display("FAIL credit_rsp_count: got %0d/%0d expected 5/5", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g.id !== e.id || g.warp !== e.warp || g.res !== e.res || g.fl !== e.fl) begin
        n_fail++;
        $display("FAIL credit_sb: got id=%0d warp=%0h res=%0h expected id=%0d warp=%0h res=%0h",
                 g.id, g.warp, g.res, e.id, e.warp, e.res);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t g, e;
    pipe_ready_i = 1'b0;
    req_a_i[0 +: DW] = 9'h011;
    req_b_i[0 +: DW] = 9'h022;
    req_valid_i = 4'b0001;
    step();
    req_a_i[0 +: DW] = 9'h055;
    req_b_i[0 +: DW] = 9'h066;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (req_ready_o !== '0 || {pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o} !== {1'b1, 9'h011, 9'h022, 3'd0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got rdy=%b pv=%0b a=%0h b=%0h rm=%0d expected rdy=0000 pv=1 a=11 b=22 rm=0",
                 k, req_ready_o, pipe_valid_o, pipe_a_o, pipe_b_o, pipe_rm_o);
      end
      step();
    end
    pipe_ready_i = 1'b1;
    #1;
    n_chk++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_drain_grant: got %b expected 0001", req_ready_o);
    end
    step();
    req_valid_i = '0;
    n_chk++;
    if ({pipe_valid_o, pipe_a_o, pipe_b_o} !== {1'b1, 9'h055, 9'h066}) begin
      n_fail++;
      $display("FAIL stall_b2b_issue: got pv=%0b a=%0h b=%0h expected pv=1 a=55 b=66",
               pipe_valid_o, pipe_a_o, pipe_b_o);
    end
    for (int t = 0; t < 40 && got_q.size() < 2; t++) step();
    n_chk++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL stall_rsp_count: got %0d/%0d expected 2/2", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g.id !== e.id || g.warp !== e.warp || g.res !== e.res || g.fl !== e.fl) begin
        n_fail++;
        $display("FAIL stall_sb: got id=%0d res=%0h fl=%0h expected id=%0d res=%0h fl=%0h",
                 g.id, g.res, g.fl, e.id, e.res, e.fl);
      end
    end
  endtask

  task automatic test_error();
    rsp_ready_i = 1'b0;
    orphan = 1'b1;
    #1;
    n_chk++;
    if (pipe_out_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_orphan_cycle: got ordy=%0b rv=%0b err=%0b expected ordy=1 rv=0 err=0",
               pipe_out_ready_o, rsp_valid_o, err_o);
    end
    step();
    orphan = 1'b0;
    #1;
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %0b expected 1", err_o);
    end
    repeat (3) step();
    n_chk++;
    if (err_o !== 1'b1 || pipe_out_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%0b ordy=%0b expected err=1 ordy=0", err_o, pipe_out_ready_o);
    end
    rsp_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    rsp_ready_i = 1'b0;
    req_valid_i = '1;
    repeat (3) step();
    req_valid_i = '0;
    n_chk++;
    if (inflight_o !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_pre: got infl=%0d expected 3", inflight_o);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({inflight_o, pipe_valid_o, rsp_valid_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got infl=%0d pv=%0b rv=%0b err=%0b expected all 0",
               inflight_o, pipe_valid_o, rsp_valid_o, err_o);
    end
    step();
    rst_n = 1'b1;
    rsp_ready_i = 1'b1;
    step();
    n_chk++;
    if ({inflight_o, pipe_valid_o, rsp_valid_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_after: got infl=%0d pv=%0b rv=%0b err=%0b expected all 0",
               inflight_o, pipe_valid_o, rsp_valid_o, err_o);
    end
  endtask

  initial begin
    req_valid_i  = '0;
    pipe_ready_i = 1'b1;
    rsp_ready_i  = 1'b1;
    orphan       = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a_i[i*DW +: DW]      = DW'(16 + i);
      req_b_i[i*DW +: DW]      = DW'(32 + 3 * i);
      req_rm_i[i*3 +: 3]       = 3'(i);
      req_warpid_i[i*WW +: WW] = 4'hA + 4'(i);
    end
    test_reset();
    test_round_robin();
    test_single();
    test_credit();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Shares one floating-point add pipeline among NUM_REQ requesters (e.g. warp lanes or issue ports) using round-robin arbitration.
- Registers the granted operands into a single issue slot that drives the pipe's input handshake.
- Records the requester id and warp id of every issued operation in an in-order tag FIFO.
- Returns each pipe result to its originator through a tagged response port.
- Bounds outstanding operations to MAX_INFLIGHT.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, ≥2); IDW = log2(NUM_REQ).
- EXPWIDTH, 5, exponent width; DW = EXPWIDTH+PRECISION+1.
- PRECISION, 3, stored mantissa bits.
- DEPTH_WARP, 4, warp id width.
- MAX_INFLIGHT, 4, tag FIFO depth (power of two); maximum operations issued but not yet responded.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester grant; a request is accepted when valid&ready.
- req_a_i  in  NUM_REQ*DW  operand A; requester i occupies bits [i*DW +: DW].
- req_b_i  in  NUM_REQ*DW  operand B, packed the same way.
- req_rm_i  in  NUM_REQ*3  rounding mode.
- req_warpid_i  in  NUM_REQ*DEPTH_WARP  warp id.
- pipe_valid_o  out  1  issue-slot valid to the add pipe.
- pipe_ready_i  in  1  add pipe accepts the slot.
- pipe_a_o, pipe_b_o  out  DW  issued operands.
- pipe_rm_o  out  3  issued rounding mode.
- pipe_out_valid_i  in  1  add pipe result valid.
- pipe_out_ready_o  out  1  result consumed.
- pipe_result_i  in  DW  add pipe result.
- pipe_fflags_i  in  5  add pipe flags.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_id_o  out  IDW  originating requester index.
- rsp_warpid_o  out  DEPTH_WARP  originating warp id.
- rsp_result_o  out  DW  result.
- rsp_fflags_o  out  5  flags.
- inflight_o  out  log2(MAX_INFLIGHT)+1  count of tags held in the FIFO.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n low):
  - pipe_valid_o=0; issue-slot data=0.
  - Round-robin pointer rr=0.
  - Tag FIFO empty; inflight_o=0; err_o=0.
  - All req_ready_o=0; rsp_valid_o=0.
  - Reset mid-operation discards every in-flight tag. The pipe is reset in the same domain.
- slot_free = !pipe_valid_o | pipe_ready_i.
- can_grant = slot_free & (inflight_o < MAX_INFLIGHT).
- Arbitration (combinational):
  - If can_grant, req_ready_o is one-hot: the first requester with req_valid_i set, scanning rr, rr+1, … modulo NUM_REQ.
  - Otherwise req_ready_o=0.
  - req_ready_o never depends on rsp_ready_i.
- On a grant of requester g (rising edge):
  - Slot loads a, b, rm of g; pipe_valid_o=1.
  - Tag {g, warpid_g} is pushed to the FIFO.
  - rr=g+1 (wraps NUM_REQ-1→0).
  - With no grant, rr holds.
- If slot_free and no grant, pipe_valid_o←0. Slot contents stay stable while pipe_valid_o & !pipe_ready_i.
- Issue latency: request accepted in cycle N → pipe_valid_o high in cycle N+1. Throughput is 1 per cycle while credits remain.
- Response path (combinational pass-through, no added latency):
  - rsp_valid_o = pipe_out_valid_i & fifo_nonempty.
  - pipe_out_ready_o = rsp_ready_i.
  - rsp_result_o and rsp_fflags_o come from the pipe.
  - rsp_id_o and rsp_warpid_o come from the FIFO head.
  - rsp_valid_o & rsp_ready_i pops the FIFO.
- Error: pipe_out_valid_i while the FIFO is empty sets err_o (sticky until reset). pipe_out_ready_o=1 in that case, so the orphan result is drained.
- Counting: the same-cycle push and pop leave inflight_o unchanged. Push alone increments it; pop alone decrements it.
- Because the count includes the issue slot, a full FIFO blocks new grants even when slot_free.
- FIFO read/write pointers wrap at MAX_INFLIGHT.
- Results return in issue order; the pipe is in-order.

Test Plan:
- Reset mid-traffic with 3 in flight → next cycle inflight_o=0, pipe_valid_o=0, rsp_valid_o=0, err_o=0.
- All 4 requesters valid continuously, pipe_ready_i=1, rsp_ready_i=1 → grant order 0,1,2,3,0,1. rsp_id_o follows the same order. Each response carries the correct warpid (warpid_i = 4'hA+i).
- Requester 2 only, a=9'h0_3C, b=9'h0_3C, 2-cycle pipe model → pipe_valid_o one cycle after accept. rsp_id_o=2 three cycles after accept, with result equal to the model's output.
- rsp_ready_i=0 with continuous requests → exactly 4 grants, then req_ready_o=0 and inflight_o=4. Releasing rsp_ready_i for one cycle pops 1 and allows exactly 1 new grant.
- pipe_ready_i=0 for 5 cycles after an issue → pipe_a_o, pipe_b_o and pipe_rm_o stay stable and no further grant occurs. Raising pipe_ready_i with a request present gives a back-to-back issue in the same cycle as the drain.
- pipe_out_valid_i pulsed with the FIFO empty → err_o=1 next cycle and stays 1; pipe_out_ready_o=1; rsp_valid_o=0.
